display_scan: RTL and testbench

Sequential driver directly upstream of the BCD-to-seven-segment decoder on the vote-count display. Accepts a binary vote count, converts it to four BCD digits with a shift-add-3 (double-dabble) engine, and time-multiplexes those digits onto one shared 4-bit `bcd` bus with matching active-low anode enables. Leading zeros are blanked by driving code 4'hF, which the decoder renders as all segments off.

---
 rtl/display_pkg.sv | 16 +
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/display_scan.sv | 55 +++++
 tb/tb_display_scan.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared constants, FSM state type and helpers for the vote-count display
package display_pkg;
  localparam int DIGITS = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int VALUE_W = 14;
  localparam logic [VALUE_W-1:0] MAX_COUNT = 14'd9999;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
  function automatic logic [VALUE_W-1:0] clamp_count(input logic [VALUE_W-1:0] v);
    return v > MAX_COUNT ? MAX_COUNT : v;
  endfunction
  function automatic logic [4*DIGITS-1:0] add3_nibbles(input logic [4*DIGITS-1:0] a);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = a[4*i+:4] >= 4'd5 ? a[4*i+:4] + 4'd3 : a[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter with a one-deep latest-wins pending load
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [VALUE_W-1:0]    value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits
);
  conv_state_t state, state_nx;
  logic [4*DIGITS-1:0] acc, adj;
  logic [VALUE_W-1:0] sr, pend, start_val;
  logic [3:0] cnt;
  logic pend_v, start;
  // next state; a load or pending value in COMMIT chains straight into the next conversion
  always_comb begin
    start = (state == IDLE && load) || (state == COMMIT && (load || pend_v));
    start_val = load ? clamp_count(value) : pend;
    state_nx = start ? SHIFT : state == SHIFT ? (cnt == 4'd0 ? COMMIT : SHIFT) : IDLE;
    adj = add3_nibbles(acc);
    busy = state != IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // shift-add-3 datapath, pending register and atomic digit commit
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      sr <= '0;
      cnt <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      digits <= '0;
      done <= 1'b0;
    end else begin
      done <= state == COMMIT;
      if (start) begin
        sr <= start_val;
        acc <= '0;
        cnt <= 4'd13;
      end else if (state == SHIFT) begin
        acc <= {adj[4*DIGITS-2:0], sr[VALUE_W-1]};
        sr <= sr << 1;
        cnt <= cnt - 4'd1;
      end
      if (state == COMMIT) digits <= acc;
      if (state == SHIFT && load) begin
        pend <= clamp_count(value);
        pend_v <= 1'b1;
      end else if (state == COMMIT) pend_v <= 1'b0;
    end
  end
endmodule

// File: rtl/display_scan.sv
// display_scan: multiplexes four BCD digits onto one bus with active-low anodes and leading-zero blanking
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               done,
  output logic [3:0]         bcd,
  output logic [3:0]         an
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(DIGITS);
  logic [RW-1:0] rc;
  logic [SW-1:0] slot, slot_nx;
  logic [4*DIGITS-1:0] digits, sh;
  logic wrap, eng_busy, eng_done;
  bin2bcd_seq u_conv (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(value),
    .busy(eng_busy),
    .done(eng_done),
    .digits(digits)
  );
  // next slot; shifting the slot's digit down makes the "this and all higher are zero" test one compare
  always_comb begin
    wrap = rc == RW'(REFRESH_DIV - 1);
    slot_nx = wrap ? slot + SW'(1) : slot;
    sh = digits >> {slot_nx, 2'b00};
  end
  // refresh counter, slot index and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rc <= '0;
      slot <= '0;
      an <= 4'b1110;
      bcd <= 4'h0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rc <= wrap ? '0 : rc + RW'(1);
      slot <= slot_nx;
      an <= ~(4'b0001 << slot_nx);
      bcd <= (slot_nx != '0 && sh == '0) ? BLANK_CODE : sh[3:0];
      busy <= eng_busy;
      done <= eng_done;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: self-checking bench with a behavioural model of the scanned vote display
module tb_display_scan;
  localparam int DIV = 4;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [13:0] value = '0;
  logic busy, done;
  logic [3:0] bcd, an;
  int n_cmp = 0, n_bad = 0;

  display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    return v > 9999 ? 9999 : v;
  endfunction

  function automatic logic [3:0] exp_digit(input int d, input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    return (k > 0 && d < p) ? 4'hF : 4'((d / p) % 10);
  endfunction

  // model: edge-indexed conversions (busy start+1..start+15, done at start+16) and a free-running scan
  int e = 0, s = 0, busy_from = 1, busy_until = 0, done_at = -1;
  int m_scan = 0, disp = 0, done_val = 0, cur = 0, pv_val = 0;
  bit act = 0, pv = 0, m_valid = 0, m_done = 0, m_busy = 0;

  always @(posedge clk) begin
    e++;
    if (reset) begin
      m_valid = 1; m_scan = 0; disp = 0; act = 0; pv = 0;
      busy_from = 1; busy_until = 0; done_at = -1; m_done = 0; m_busy = 0;
    end else if (m_valid) begin
      m_scan++;
      m_done = (e == done_at);
      if (m_done) disp = done_val;
      if (act && e == s + 15) begin
        done_at = e + 1;
        done_val = cur;
        if (load || pv) begin
          cur = load ? clampi(int'(value)) : pv_val;
          pv = 0; s = e; busy_until = e + 15;
        end else act = 0;
      end else if (load) begin
        if (act) begin
          pv = 1; pv_val = clampi(int'(value));
        end else begin
          act = 1; s = e; cur = clampi(int'(value));
          busy_from = e + 1; busy_until = e + 15;
        end
      end
      m_busy = e >= busy_from && e <= busy_until;
    end
  end

  always @(negedge clk) begin
    int slot;
    logic [3:0] ea;
    if (m_valid) begin
      slot = (m_scan / DIV) % 4;
      ea = ~(4'b0001 << slot);
      chk("an", an, ea);
      chk("bcd", bcd, exp_digit(disp, slot));
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("an_onehot_low", $countones(~an), 1);
    end
  end

  task automatic do_load(input int v);
    @(negedge clk);
    load = 1'b1;
    value = 14'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        return;
      end
    end
    chk("done_wait_timeout", 0, 1);
  endtask

  task automatic grab(input int n, output logic [15:0] d);
    d = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (an == ~(4'b0001 << k)) d[4*k+:4] = bcd;
    end
  endtask

  initial begin
    int lat, nd;
    logic [15:0] d;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("idle_busy", busy, 0);
    grab(16, d);
    chk("idle_scan", d, 16'hFFF0);
    do_load(1234);
    wait_done(lat);
    chk("latency_1234", lat, 16);
    grab(16, d);
    chk("show_1234", d, 16'h1234);
    do_load(10000);
    wait_done(lat);
    grab(16, d);
    chk("show_clamp", d, 16'h9999);
    do_load(7);
    wait_done(lat);
    grab(16, d);
    chk("show_7", d, 16'hFFF7);
    do_load(1005);
    wait_done(lat);
    grab(16, d);
    chk("show_1005", d, 16'h1005);
    do_load(42);
    repeat (4) @(negedge clk);
    load = 1'b1; value = 14'd300;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    load = 1'b1; value = 14'd8;
    @(negedge clk);
    load = 1'b0;
    wait_done(lat);
    grab(13, d);
    chk("show_42", d, 16'hFF42);
    wait_done(lat);
    grab(16, d);
    chk("show_8_latest", d, 16'hFFF8);
    do_load(9999);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_bcd", bcd, 4'h0);
    reset = 1'b0;
    nd = 0;
    repeat (24) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_load(int'($urandom_range(0, 16383)));
    end
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
